// File: rtl/card_judge.sv
// Scores drawn cards against the table-top card, keeps a circular hand per player
// and flags the winner. Optional `CARD_JUDGE_PENALTY_EN: a "neither" match in PLAY costs 1 point.
module card_judge #(
  parameter int HAND_DEPTH = 4,
  parameter int SCORE_W    = 8,
  parameter int WIN_SCORE  = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          card_valid,
  input  logic                          whose,
  input  logic [1:0]                    color,
  input  logic [2:0]                    number,
  input  logic                          restart,
  output logic [SCORE_W-1:0]            score1,
  output logic [SCORE_W-1:0]            score2,
  output logic [4:0]                    top_card,
  output logic [$clog2(HAND_DEPTH):0]   hand_cnt1,
  output logic [$clog2(HAND_DEPTH):0]   hand_cnt2,
  input  logic                          rd_player,
  input  logic [$clog2(HAND_DEPTH)-1:0] rd_idx,
  output logic [4:0]                    rd_card,
  output logic                          finish,
  output logic                          game_over,
  output logic                          winner
);

  localparam int IW = $clog2(HAND_DEPTH);
  localparam logic [IW:0]        CNT_FULL = (IW+1)'(HAND_DEPTH);
  localparam logic [SCORE_W-1:0] WIN_V    = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state;

  logic [4:0]    hand1 [HAND_DEPTH];
  logic [4:0]    hand2 [HAND_DEPTH];
  logic [IW-1:0] wp1, wp2;

  logic               legal, same_c, same_n, win;
  logic [3:0]         gain;
  logic [SCORE_W-1:0] cur, new_score;
  logic [SCORE_W:0]   sum;
  logic [4:0]         card;
`ifdef CARD_JUDGE_PENALTY_EN
  logic               penal;
`endif

  always_comb begin
    card   = {color, number};
    legal  = (color != 2'd0) && (number >= 3'd1) && (number <= 3'd5);
    cur    = whose ? score2 : score1;
    same_c = (color == top_card[4:3]);
    same_n = (number == top_card[2:0]);
    gain   = 4'd0;
`ifdef CARD_JUDGE_PENALTY_EN
    penal  = 1'b0;
`endif
    if (state == PLAY) begin
      if (same_c && same_n) gain = {number, 1'b0};
      else if (same_c)      gain = {1'b0, number};
      else if (same_n)      gain = 4'd1;
`ifdef CARD_JUDGE_PENALTY_EN
      else                  penal = 1'b1;
`endif
    end
    sum       = {1'b0, cur} + (SCORE_W+1)'(gain);
    new_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
`ifdef CARD_JUDGE_PENALTY_EN
    if (penal && cur != '0) new_score = cur - 1'b1;
`endif
    win = (new_score >= WIN_V);
  end

  // Oldest card sits count slots behind the write pointer (mod depth)
  logic [IW-1:0] ridx1, ridx2;
  always_comb begin
    ridx1   = wp1 - hand_cnt1[IW-1:0] + rd_idx;
    ridx2   = wp2 - hand_cnt2[IW-1:0] + rd_idx;
    rd_card = '0;
    if (!rd_player) begin
      if ({1'b0, rd_idx} < hand_cnt1) rd_card = hand1[ridx1];
    end else begin
      if ({1'b0, rd_idx} < hand_cnt2) rd_card = hand2[ridx2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      state     <= IDLE;
      score1    <= '0;
      score2    <= '0;
      top_card  <= '0;
      hand_cnt1 <= '0;
      hand_cnt2 <= '0;
      wp1       <= '0;
      wp2       <= '0;
      finish    <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      for (int unsigned i = 0; i < HAND_DEPTH; i++) begin
        hand1[i] <= '0;
        hand2[i] <= '0;
      end
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE, PLAY: begin
          if (card_valid && legal) begin
            top_card <= card;
            if (whose) begin
              score2       <= new_score;
              hand2[wp2]   <= card;
              wp2          <= wp2 + 1'b1;
              if (hand_cnt2 != CNT_FULL) hand_cnt2 <= hand_cnt2 + 1'b1;
            end else begin
              score1       <= new_score;
              hand1[wp1]   <= card;
              wp1          <= wp1 + 1'b1;
              if (hand_cnt1 != CNT_FULL) hand_cnt1 <= hand_cnt1 + 1'b1;
            end
            if (win) begin
              state     <= OVER;
              finish    <= 1'b1;
              game_over <= 1'b1;
              winner    <= whose;
            end else begin
              state <= PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
